// File: rtl/axi_dw_sched_pkg.sv
// Shared types and the narrow-beat arithmetic for the downsizing read scheduler.
// Latency: none (types and a pure function).
// Backpressure: n/a.
package axi_dw_sched_pkg;

    typedef logic [1:0] state_e;
    localparam state_e IDLE = 2'd0;
    localparam state_e FWD  = 2'd1;
    localparam state_e ERR  = 2'd2;

    localparam logic [1:0] BURST_INCR = 2'b01;

    typedef struct packed {
        logic       valid;
        logic [7:0] bpw;       // narrow beats per wide beat
        logic [7:0] pack_cnt;  // narrow beats left in the current wide beat
        logic [8:0] rem;       // wide beats left in the burst
    } slot_t;

    typedef struct packed {
        logic [2:0]  size;
        logic [7:0]  bpw;
        logic [7:0]  off;
        logic [16:0] total;
    } narrow_t;

    // mst_b is log2 of the narrow bus byte width; off is the narrow lane the burst starts on.
    function automatic narrow_t calc_narrow_beats(input logic [15:0] addr, input logic [7:0] len,
                                                  input logic [2:0] size, input logic [2:0] mst_b);
        narrow_t n;
        n.size  = size;
        n.bpw   = 8'd1;
        n.off   = 8'd0;
        n.total = 17'(len) + 17'd1;
        if (size > mst_b) begin
            n.size  = mst_b;
            n.bpw   = 8'd1 << (size - mst_b);
            n.off   = 8'(addr >> mst_b) & (n.bpw - 8'd1);
            n.total = (17'(len) + 17'd1) * 17'(n.bpw) - 17'(n.off);
        end
        return n;
    endfunction

endpackage

// File: rtl/axi_dw_rd_scheduler_if.sv
// AR/R sideband bundle between the downsizer datapath and the read scheduler.
// Latency: none (wires only).
// Backpressure: valid/ready on slave AR, master AR and error R.
interface axi_dw_rd_scheduler_if #(
    parameter int unsigned IdWidth   = 4,
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned SlotWidth = 2
);
    logic                 slv_ar_valid;
    logic                 slv_ar_ready;
    logic [IdWidth-1:0]   slv_ar_id;
    logic [AddrWidth-1:0] slv_ar_addr;
    logic [7:0]           slv_ar_len;
    logic [2:0]           slv_ar_size;
    logic [1:0]           slv_ar_burst;
    logic                 mst_ar_valid;
    logic                 mst_ar_ready;
    logic [IdWidth-1:0]   mst_ar_id;
    logic [AddrWidth-1:0] mst_ar_addr;
    logic [7:0]           mst_ar_len;
    logic [2:0]           mst_ar_size;
    logic                 mst_r_hs;
    logic [IdWidth-1:0]   mst_r_id;
    logic [SlotWidth-1:0] r_slot;
    logic                 r_slot_valid;
    logic                 r_pack_last;
    logic                 r_burst_last;
    logic                 r_unexp;
    logic                 err_r_valid;
    logic                 err_r_ready;
    logic [IdWidth-1:0]   err_r_id;
    logic                 err_r_last;

    modport slave (
        input  slv_ar_valid, slv_ar_id, slv_ar_addr, slv_ar_len, slv_ar_size, slv_ar_burst,
        input  mst_ar_ready, mst_r_hs, mst_r_id, err_r_ready,
        output slv_ar_ready, mst_ar_valid, mst_ar_id, mst_ar_addr, mst_ar_len, mst_ar_size,
        output r_slot, r_slot_valid, r_pack_last, r_burst_last, r_unexp,
        output err_r_valid, err_r_id, err_r_last
    );

    modport master (
        output slv_ar_valid, slv_ar_id, slv_ar_addr, slv_ar_len, slv_ar_size, slv_ar_burst,
        output mst_ar_ready, mst_r_hs, mst_r_id, err_r_ready,
        input  slv_ar_ready, mst_ar_valid, mst_ar_id, mst_ar_addr, mst_ar_len, mst_ar_size,
        input  r_slot, r_slot_valid, r_pack_last, r_burst_last, r_unexp,
        input  err_r_valid, err_r_id, err_r_last
    );
endinterface

// File: rtl/axi_dw_age_matrix.sv
// Age matrix over read slots: picks the oldest slot among a match mask.
// Latency: selection combinational; age updated on the allocation edge.
// Backpressure: none.
module axi_dw_age_matrix #(
    parameter int unsigned NumSlots = 4,
    parameter int unsigned SlotW    = 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                alloc_vld,
    input  logic [SlotW-1:0]    alloc_idx,
    input  logic [NumSlots-1:0] valid,
    input  logic [NumSlots-1:0] match,
    output logic [SlotW-1:0]    oldest_idx,
    output logic                oldest_vld
);
    // older_q[i][j] set: slot i was allocated before slot j
    logic [NumSlots-1:0] older_q [NumSlots];
    logic                blocked;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NumSlots; i++) older_q[i] <= '0;
        end else if (alloc_vld) begin
            for (int i = 0; i < NumSlots; i++) begin
                if (alloc_idx == SlotW'(i)) older_q[i] <= '0;
                else                        older_q[i][alloc_idx] <= valid[i];
            end
        end
    end

    always_comb begin
        oldest_idx = '0;
        oldest_vld = 1'b0;
        blocked    = 1'b0;
        for (int i = 0; i < NumSlots; i++) begin
            blocked = 1'b0;
            for (int j = 0; j < NumSlots; j++)
                if (match[j] && older_q[j][i]) blocked = 1'b1;
            if (match[i] && !blocked) begin
                oldest_idx = SlotW'(i);
                oldest_vld = 1'b1;
            end
        end
    end
endmodule

// File: rtl/axi_dw_rd_scheduler.sv
// Downsizer read sequencer: slot allocation, narrow AR rewrite, R beat tagging, SLVERR for bad bursts.
// Latency: master AR valid one cycle after slave AR accept; R tags are combinational on mst_r_id.
// Backpressure: slave AR stalls outside IDLE or when all slots busy; AXI_DW_SCHED_PERF_EN adds counters.
module axi_dw_rd_scheduler
    import axi_dw_sched_pkg::*;
#(
    parameter int unsigned AxiMaxReads     = 4,
    parameter int unsigned AxiIdWidth      = 4,
    parameter int unsigned AxiAddrWidth    = 32,
    parameter int unsigned AxiMstDataWidth = 32,
    parameter int unsigned AxiSlvDataWidth = 64
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    axi_dw_rd_scheduler_if.slave   bus
`ifdef AXI_DW_SCHED_PERF_EN
    ,
    output logic [31:0]            perf_ar_cnt_o,
    output logic [31:0]            perf_err_cnt_o
`endif
);
    localparam int unsigned SlotW = (AxiMaxReads > 1) ? $clog2(AxiMaxReads) : 1;
    localparam logic [2:0]  MstB  = 3'($clog2(AxiMstDataWidth / 8));

    if (AxiSlvDataWidth <= AxiMstDataWidth) begin : g_bad_cfg
        $error("axi_dw_rd_scheduler: slave width must exceed master width");
    end

    state_e                  state_q;
    logic                    init_q;
    slot_t                   slot_q    [AxiMaxReads];
    logic [AxiIdWidth-1:0]   slot_id_q [AxiMaxReads];
    logic [AxiMaxReads-1:0]  valid_mask, match;
    logic [SlotW-1:0]        alloc_idx, r_idx;
    logic                    r_found, r_hit, ar_hs, ar_ok, alloc;
    logic [7:0]              err_cnt_q;
    logic [AxiIdWidth-1:0]   err_id_q;
    narrow_t                 nb;
    slot_t                   cur;

    always_comb begin
        valid_mask = '0;
        match      = '0;
        alloc_idx  = '0;
        for (int i = AxiMaxReads - 1; i >= 0; i--) begin
            valid_mask[i] = slot_q[i].valid;
            match[i]      = slot_q[i].valid && (slot_id_q[i] == bus.mst_r_id);
            if (!slot_q[i].valid) alloc_idx = SlotW'(i);
        end
    end

    // init_q keeps AR ready low while in reset and for the first cycle after it
    assign bus.slv_ar_ready = init_q && (state_q == IDLE) && !(&valid_mask);
    assign ar_hs = bus.slv_ar_valid && bus.slv_ar_ready;
    assign nb    = calc_narrow_beats(16'(bus.slv_ar_addr), bus.slv_ar_len, bus.slv_ar_size, MstB);
    assign ar_ok = (bus.slv_ar_burst == BURST_INCR) && (nb.total <= 17'd256);
    assign alloc = ar_hs && ar_ok;

    axi_dw_age_matrix #(.NumSlots(AxiMaxReads), .SlotW(SlotW)) u_age (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .alloc_vld  (alloc),
        .alloc_idx  (alloc_idx),
        .valid      (valid_mask),
        .match      (match),
        .oldest_idx (r_idx),
        .oldest_vld (r_found)
    );

    assign cur              = slot_q[r_idx];
    assign r_hit            = bus.mst_r_hs && r_found;
    assign bus.r_slot       = r_idx;
    assign bus.r_slot_valid = r_found;
    assign bus.r_pack_last  = r_found && (cur.pack_cnt == 8'd1);
    assign bus.r_burst_last = bus.r_pack_last && (cur.rem == 9'd1);
    assign bus.r_unexp      = bus.mst_r_hs && !r_found;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < AxiMaxReads; i++) begin
                slot_q[i]    <= '0;
                slot_id_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < AxiMaxReads; i++) begin
                if (r_hit && (r_idx == SlotW'(i))) begin
                    if (bus.r_pack_last) begin
                        slot_q[i].pack_cnt <= slot_q[i].bpw;
                        slot_q[i].rem      <= slot_q[i].rem - 9'd1;
                    end else begin
                        slot_q[i].pack_cnt <= slot_q[i].pack_cnt - 8'd1;
                    end
                    if (bus.r_burst_last) slot_q[i].valid <= 1'b0;
                end
                if (alloc && (alloc_idx == SlotW'(i))) begin
                    slot_q[i].valid    <= 1'b1;
                    slot_q[i].bpw      <= nb.bpw;
                    slot_q[i].pack_cnt <= nb.bpw - nb.off;
                    slot_q[i].rem      <= 9'(bus.slv_ar_len) + 9'd1;
                    slot_id_q[i]       <= bus.slv_ar_id;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q         <= IDLE;
            init_q          <= 1'b0;
            bus.mst_ar_id   <= '0;
            bus.mst_ar_addr <= '0;
            bus.mst_ar_len  <= '0;
            bus.mst_ar_size <= '0;
            err_cnt_q       <= '0;
            err_id_q        <= '0;
        end else begin
            init_q <= 1'b1;
            case (state_q)
                IDLE: if (ar_hs) begin
                    if (ar_ok) begin
                        state_q         <= FWD;
                        bus.mst_ar_id   <= bus.slv_ar_id;
                        bus.mst_ar_addr <= bus.slv_ar_addr;
                        bus.mst_ar_len  <= 8'(nb.total - 17'd1);
                        bus.mst_ar_size <= nb.size;
                    end else begin
                        state_q   <= ERR;
                        err_cnt_q <= bus.slv_ar_len;
                        err_id_q  <= bus.slv_ar_id;
                    end
                end
                FWD: if (bus.mst_ar_ready) state_q <= IDLE;
                ERR: if (bus.err_r_ready) begin
                    if (err_cnt_q == 8'd0) state_q <= IDLE;
                    else                   err_cnt_q <= err_cnt_q - 8'd1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.mst_ar_valid = (state_q == FWD);
    assign bus.err_r_valid  = (state_q == ERR);
    assign bus.err_r_last   = (state_q == ERR) && (err_cnt_q == 8'd0);
    assign bus.err_r_id     = err_id_q;

`ifdef AXI_DW_SCHED_PERF_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_ar_cnt_o  <= '0;
            perf_err_cnt_o <= '0;
        end else begin
            if (ar_hs && (perf_ar_cnt_o != '1))            perf_ar_cnt_o  <= perf_ar_cnt_o + 32'd1;
            if (ar_hs && !ar_ok && (perf_err_cnt_o != '1)) perf_err_cnt_o <= perf_err_cnt_o + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_axi_dw_rd_scheduler.sv
// Self-checking bench for the 64->32 read scheduler with 4 slots.
// Expected slot/pack/burst flags come from a burst-level scoreboard.
module tb_axi_dw_rd_scheduler;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    axi_dw_rd_scheduler_if #(.IdWidth(4), .AddrWidth(32), .SlotWidth(2)) bus ();

    axi_dw_rd_scheduler #(
        .AxiMaxReads(4), .AxiIdWidth(4), .AxiAddrWidth(32),
        .AxiMstDataWidth(32), .AxiSlvDataWidth(64)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus.slave)
    );

    // Scoreboard: one entry per outstanding burst, indexed by the slot it should own.
    bit         m_valid [4];
    logic [3:0] m_id    [4];
    int         m_bpw [4], m_off [4], m_total [4], m_beat [4], m_seq [4];
    int         seq_ctr = 0;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic ref_narrow(input logic [31:0] addr, input int len, input int size,
                              output int msize, output int bpw, output int off, output int total);
        if (size <= 2) begin
            msize = size; bpw = 1; off = 0; total = len + 1;
        end else begin
            msize = 2;
            bpw   = 1 << (size - 2);
            off   = int'((addr >> 2) % 32'(bpw));
            total = (len + 1) * bpw - off;
        end
    endtask

    function automatic int lowest_free();
        int s = -1;
        for (int i = 3; i >= 0; i--) if (!m_valid[i]) s = i;
        return s;
    endfunction

    function automatic int model_alloc(input logic [3:0] id, input int bpw, input int off, input int total);
        int s = lowest_free();
        m_valid[s] = 1'b1; m_id[s] = id; m_bpw[s] = bpw; m_off[s] = off;
        m_total[s] = total; m_beat[s] = 0; m_seq[s] = seq_ctr;
        seq_ctr++;
        return s;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;
    endtask

    task automatic do_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input bit exp_rdy, output bit acc);
        acc = 1'b0;
        @(negedge clk);
        bus.slv_ar_id = id; bus.slv_ar_addr = addr; bus.slv_ar_len = len;
        bus.slv_ar_size = size; bus.slv_ar_burst = burst; bus.slv_ar_valid = 1'b1;
        #1;
        checks++;
        if (bus.slv_ar_ready !== exp_rdy || bus.mst_ar_valid !== 1'b0) begin
            errors++;
            $display("FAIL ar_ready_pre: ready=%0b exp=%0b mst_ar_valid=%0b exp=0",
                     bus.slv_ar_ready, exp_rdy, bus.mst_ar_valid);
        end
        for (int c = 0; c < 50 && !acc; c++) begin
            if (bus.slv_ar_ready === 1'b1) begin
                @(posedge clk);
                acc = 1'b1;
            end else begin
                @(negedge clk);
                #1;
            end
        end
        #1;
        bus.slv_ar_valid = 1'b0;
    endtask

    task automatic take_mst_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size);
        checks++;
        if (bus.mst_ar_valid !== 1'b1 || bus.mst_ar_id !== id || bus.mst_ar_addr !== addr ||
            bus.mst_ar_len !== len || bus.mst_ar_size !== size) begin
            errors++;
            $display("FAIL mst_ar: valid=%0b id=%0h addr=%08h len=%0d size=%0d exp id=%0h addr=%08h len=%0d size=%0d",
                     bus.mst_ar_valid, bus.mst_ar_id, bus.mst_ar_addr, bus.mst_ar_len, bus.mst_ar_size,
                     id, addr, len, size);
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus.mst_ar_valid !== 1'b1 || bus.mst_ar_len !== len) begin
            errors++;
            $display("FAIL mst_ar_hold: valid=%0b len=%0d exp valid=1 len=%0d", bus.mst_ar_valid, bus.mst_ar_len, len);
        end
        bus.mst_ar_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.mst_ar_ready = 1'b0;
        checks++;
        if (bus.mst_ar_valid !== 1'b0) begin
            errors++;
            $display("FAIL mst_ar_drop: valid=%0b exp=0", bus.mst_ar_valid);
        end
    endtask

    task automatic collect_err(input int exp_n, input logic [3:0] exp_id);
        int n = 0;
        int bad_last = 0;
        int bad_misc = 0;
        bit done = 1'b0;
        for (int c = 0; c < exp_n * 4 + 20 && !done; c++) begin
            @(negedge clk);
            bus.err_r_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (bus.mst_ar_valid !== 1'b0 || bus.err_r_valid !== 1'b1 || bus.err_r_id !== exp_id) bad_misc++;
            if (bus.err_r_valid === 1'b1 && bus.err_r_ready) begin
                n++;
                if (bus.err_r_last !== (n == exp_n)) bad_last++;
                if (bus.err_r_last === 1'b1) done = 1'b1;
            end
            @(posedge clk);
        end
        #1;
        bus.err_r_ready = 1'b0;
        checks++;
        if (n != exp_n || bad_last != 0 || bad_misc != 0 || bus.err_r_valid !== 1'b0) begin
            errors++;
            $display("FAIL err_burst: beats=%0d exp=%0d bad_last=%0d bad_misc=%0d valid_after=%0b exp 0/0/0",
                     n, exp_n, bad_last, bad_misc, bus.err_r_valid);
        end
    endtask

    task automatic issue(input logic [3:0] id, input logic [31:0] addr, input int len, input int size, input logic [1:0] burst);
        int msize, bpw, off, total, s;
        bit acc, exp_ok;
        ref_narrow(addr, len, size, msize, bpw, off, total);
        exp_ok = (burst == 2'b01) && (total <= 256);
        do_ar(id, addr, 8'(len), 3'(size), burst, lowest_free() >= 0, acc);
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL ar_accept: accepted=0 exp=1 (id=%0h len=%0d size=%0d)", id, len, size);
            return;
        end
        if (exp_ok) begin
            s = model_alloc(id, bpw, off, total);
            take_mst_ar(id, addr, 8'(total - 1), 3'(msize));
        end else begin
            collect_err(len + 1, id);
        end
    endtask

    // ar_rdy_exp: -1 skips the slave AR ready check during the beat
    task automatic r_beat(input logic [3:0] id, input int ar_rdy_exp);
        int own = -1;
        bit exp_pack, exp_last;
        for (int i = 0; i < 4; i++)
            if (m_valid[i] && m_id[i] == id && (own < 0 || m_seq[i] < m_seq[own])) own = i;
        @(negedge clk);
        bus.mst_r_hs = 1'b1;
        bus.mst_r_id = id;
        #1;
        checks++;
        if (own < 0) begin
            if (bus.r_unexp !== 1'b1 || bus.r_slot_valid !== 1'b0) begin
                errors++;
                $display("FAIL r_unexp: unexp=%0b slot_valid=%0b exp 1/0 (id=%0h)", bus.r_unexp, bus.r_slot_valid, id);
            end
        end else begin
            exp_pack = ((m_off[own] + m_beat[own] + 1) % m_bpw[own]) == 0;
            exp_last = (m_beat[own] + 1) == m_total[own];
            if (bus.r_slot_valid !== 1'b1 || bus.r_slot !== 2'(own) || bus.r_pack_last !== exp_pack ||
                bus.r_burst_last !== exp_last || bus.r_unexp !== 1'b0) begin
                errors++;
                $display("FAIL r_map: id=%0h beat=%0d slot=%0d/%0b pack=%0b last=%0b unexp=%0b exp slot=%0d pack=%0b last=%0b",
                         id, m_beat[own], bus.r_slot, bus.r_slot_valid, bus.r_pack_last, bus.r_burst_last,
                         bus.r_unexp, own, exp_pack, exp_last);
            end
            m_beat[own]++;
            if (exp_last) m_valid[own] = 1'b0;
        end
        if (ar_rdy_exp >= 0) begin
            checks++;
            if (bus.slv_ar_ready !== 1'(ar_rdy_exp)) begin
                errors++;
                $display("FAIL ar_ready_in_free_cycle: ready=%0b exp=%0d", bus.slv_ar_ready, ar_rdy_exp);
            end
        end
        @(posedge clk);
        #1;
        bus.mst_r_hs = 1'b0;
    endtask

    task automatic test_reset();
        bus.slv_ar_valid = 0; bus.slv_ar_id = 0; bus.slv_ar_addr = 0; bus.slv_ar_len = 0;
        bus.slv_ar_size = 0; bus.slv_ar_burst = 0; bus.mst_ar_ready = 0; bus.mst_r_hs = 0;
        bus.mst_r_id = 0; bus.err_r_ready = 0;
        clear_model();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.slv_ar_ready !== 0 || bus.mst_ar_valid !== 0 || bus.err_r_valid !== 0 || bus.err_r_last !== 0 ||
            bus.r_slot_valid !== 0 || bus.r_unexp !== 0 || bus.r_pack_last !== 0 || bus.r_burst_last !== 0 ||
            bus.mst_ar_len !== 0 || bus.mst_ar_size !== 0 || bus.mst_ar_id !== 0 || bus.mst_ar_addr !== 0) begin
            errors++;
            $display("FAIL reset_outputs: ar_rdy=%0b mst_v=%0b err_v=%0b slot_v=%0b unexp=%0b exp all 0",
                     bus.slv_ar_ready, bus.mst_ar_valid, bus.err_r_valid, bus.r_slot_valid, bus.r_unexp);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.slv_ar_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset: ready=%0b exp=1", bus.slv_ar_ready);
        end
    endtask

    task automatic test_narrow_bursts();
        issue(4'd1, 32'h0, 1, 3, 2'b01);
        for (int k = 0; k < 4; k++) r_beat(4'd1, -1);
        issue(4'd2, 32'h4, 0, 3, 2'b01);
        r_beat(4'd2, -1);
        issue(4'd3, 32'h10, 7, 2, 2'b01);
        for (int k = 0; k < 8; k++) r_beat(4'd3, -1);
        issue(4'd4, 32'h21, 3, 0, 2'b01);
        for (int k = 0; k < 4; k++) r_beat(4'd4, -1);
    endtask

    task automatic test_len_limit();
        issue(4'd5, 32'h100, 127, 3, 2'b01);
        for (int k = 0; k < 256; k++) r_beat(4'd5, -1);
        issue(4'd6, 32'h104, 127, 3, 2'b01);
        for (int k = 0; k < 255; k++) r_beat(4'd6, -1);
    endtask

    task automatic test_err();
        issue(4'd7, 32'h0, 3, 2, 2'b10);
        issue(4'd8, 32'h0, 200, 3, 2'b01);
        issue(4'd9, 32'h4, 128, 3, 2'b01);
        issue(4'd10, 32'h0, 0, 2, 2'b00);
    endtask

    task automatic test_unexp();
        issue(4'd3, 32'h8, 1, 3, 2'b01);
        r_beat(4'd12, -1);
        for (int k = 0; k < 4; k++) r_beat(4'd3, -1);
        r_beat(4'd3, -1);
    endtask

    task automatic test_fill_stall();
        int s;
        for (int k = 0; k < 4; k++) issue(4'd1, 32'(k * 8), 0, 2, 2'b01);
        @(negedge clk);
        bus.slv_ar_id = 4'd1; bus.slv_ar_addr = 32'h40; bus.slv_ar_len = 8'd0;
        bus.slv_ar_size = 3'd2; bus.slv_ar_burst = 2'b01; bus.slv_ar_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (bus.slv_ar_ready !== 1'b0) begin
                errors++;
                $display("FAIL ar_full_stall: ready=%0b exp=0", bus.slv_ar_ready);
            end
            @(negedge clk);
        end
        r_beat(4'd1, 0);
        checks++;
        if (bus.slv_ar_ready !== 1'b1) begin
            errors++;
            $display("FAIL ar_ready_after_free: ready=%0b exp=1", bus.slv_ar_ready);
        end
        @(posedge clk);
        s = model_alloc(4'd1, 1, 0, 1);
        #1;
        bus.slv_ar_valid = 1'b0;
        take_mst_ar(4'd1, 32'h40, 8'd0, 3'd2);
        for (int k = 0; k < 4; k++) r_beat(4'd1, -1);
    endtask

    task automatic test_random();
        int lens [10] = '{0, 1, 2, 3, 4, 5, 6, 7, 127, 128};
        for (int it = 0; it < 60; it++) begin
            int vs [$];
            for (int i = 0; i < 4; i++) if (m_valid[i]) vs.push_back(i);
            if (vs.size() < 4 && $urandom_range(0, 2) == 0) begin
                issue(4'($urandom_range(0, 3)), $urandom, lens[$urandom_range(0, 9)],
                      int'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b01);
            end else if (vs.size() > 0 && $urandom_range(0, 7) != 0) begin
                r_beat(m_id[vs[$urandom_range(0, 32'(vs.size() - 1))]], -1);
            end else begin
                r_beat(4'($urandom_range(8, 15)), -1);
            end
        end
        for (int g = 0; g < 3000; g++) begin
            int s = -1;
            for (int i = 0; i < 4; i++) if (m_valid[i]) s = i;
            if (s < 0) break;
            r_beat(m_id[s], -1);
        end
    endtask

    task automatic test_reset_mid_burst();
        issue(4'd2, 32'h0, 3, 3, 2'b01);
        issue(4'd3, 32'h0, 1, 2, 2'b01);
        r_beat(4'd2, -1);
        r_beat(4'd2, -1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.slv_ar_ready !== 0 || bus.mst_ar_valid !== 0 || bus.err_r_valid !== 0 || bus.r_slot_valid !== 0 ||
            bus.r_pack_last !== 0 || bus.r_burst_last !== 0 || bus.r_unexp !== 0 || bus.mst_ar_len !== 0 ||
            bus.r_slot !== 0) begin
            errors++;
            $display("FAIL reset_mid_burst: ar_rdy=%0b mst_v=%0b slot_v=%0b pack=%0b last=%0b exp all 0",
                     bus.slv_ar_ready, bus.mst_ar_valid, bus.r_slot_valid, bus.r_pack_last, bus.r_burst_last);
        end
        clear_model();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        r_beat(4'd3, -1);
        issue(4'd2, 32'h8, 0, 3, 2'b01);
        r_beat(4'd2, -1);
        r_beat(4'd2, -1);
    endtask

    initial begin
        test_reset();
        test_narrow_bursts();
        test_len_limit();
        test_err();
        test_unexp();
        test_fill_stall();
        test_random();
        test_reset_mid_burst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
